// File: rtl/tlb_ctrl_if.sv
// Bundle of requester, CP0-write and TLB-array signals around tlb_ctrl.
// slave is the controller's view; master is the view of everything around it.
interface tlb_ctrl_if;
  logic        if_req;
  logic [31:0] if_vaddr;
  logic        if_ack;
  logic [31:0] if_paddr;
  logic        if_miss;
  logic        mem_req;
  logic [31:0] mem_vaddr;
  logic        mem_ack;
  logic [31:0] mem_paddr;
  logic        mem_miss;
  logic        tlbw_req;
  logic        tlbw_random;
  logic        tlbw_ack;
  logic [31:0] tlb_addr_o;
  logic [31:0] tlb_inst_o;
  logic        tlb_hit_i;
  logic [31:0] tlb_paddr_i;
  logic [3:0]  wired_i;
  logic [3:0]  random_o;
  logic [31:0] badvaddr_o;

  modport slave (
    input  if_req, if_vaddr, mem_req, mem_vaddr, tlbw_req, tlbw_random,
           tlb_hit_i, tlb_paddr_i, wired_i,
    output if_ack, if_paddr, if_miss, mem_ack, mem_paddr, mem_miss, tlbw_ack,
           tlb_addr_o, tlb_inst_o, random_o, badvaddr_o
  );

  modport master (
    output if_req, if_vaddr, mem_req, mem_vaddr, tlbw_req, tlbw_random,
           tlb_hit_i, tlb_paddr_i, wired_i,
    input  if_ack, if_paddr, if_miss, mem_ack, mem_paddr, mem_miss, tlbw_ack,
           tlb_addr_o, tlb_inst_o, random_o, badvaddr_o
  );
endinterface

// File: rtl/tlb_ctrl.sv
// TLB access controller: arbitrates fetch/memory lookups and CP0 TLB writes,
// applies kseg0/kseg1 bypass and maintains the CP0 Random index.
module tlb_ctrl #(
  parameter int NUM_ENTRIES = 16,
  parameter bit KSEG_BYPASS = 1'b1
) (
  input logic       clk,
  input logic       rst,
  tlb_ctrl_if.slave bus
);
  localparam logic [3:0] RAND_TOP = 4'(NUM_ENTRIES - 1);
  localparam logic [31:0] INST_TLBWI = 32'h42000002;
  localparam logic [31:0] INST_TLBWR = 32'h42000006;

  typedef enum logic [2:0] {IDLE, LOOKUP, RESP, WRITE, WACK} state_t;

  state_t      state_reg, state_next;
  logic [31:0] vaddr_reg, vaddr_next;
  logic        gnt_mem_reg, gnt_mem_next;
  logic        rr_mem_reg, rr_mem_next;
  logic        wr_random_reg, wr_random_next;
  logic [3:0]  random_reg, random_next;
  logic        hit_reg;
  logic [31:0] if_paddr_reg, mem_paddr_reg, badvaddr_reg;
  logic        pick_mem;
  logic        bypass;
  logic        lookup_hit;
  logic [31:0] lookup_paddr;

  // kseg0/kseg1 are unmapped: strip the segment bits instead of asking the TLB
  assign bypass       = KSEG_BYPASS && (vaddr_reg[31:30] == 2'b10);
  assign lookup_hit   = bypass || bus.tlb_hit_i;
  assign lookup_paddr = bypass ? {3'b000, vaddr_reg[28:0]} : bus.tlb_paddr_i;

  always_comb begin
    state_next     = state_reg;
    vaddr_next     = vaddr_reg;
    gnt_mem_next   = gnt_mem_reg;
    rr_mem_next    = rr_mem_reg;
    wr_random_next = wr_random_reg;
    pick_mem       = 1'b0;
    case (state_reg)
      IDLE: begin
        if (bus.tlbw_req) begin
          wr_random_next = bus.tlbw_random;
          state_next     = WRITE;
        end else if (bus.if_req || bus.mem_req) begin
          // on a tie the requester not granted last time wins
          pick_mem     = bus.mem_req && (!bus.if_req || !rr_mem_reg);
          gnt_mem_next = pick_mem;
          rr_mem_next  = pick_mem;
          vaddr_next   = pick_mem ? bus.mem_vaddr : bus.if_vaddr;
          state_next   = LOOKUP;
        end
      end
      LOOKUP:  state_next = RESP;
      RESP:    state_next = IDLE;
      WRITE:   state_next = WACK;
      WACK:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Random freezes while TLBWR is using it so the written index is stable
  always_comb begin
    random_next = random_reg;
    if (!(state_reg == WRITE && wr_random_reg)) begin
      if (bus.wired_i == RAND_TOP || random_reg <= bus.wired_i)
        random_next = RAND_TOP;
      else
        random_next = random_reg - 4'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= IDLE;
      vaddr_reg     <= '0;
      gnt_mem_reg   <= 1'b0;
      rr_mem_reg    <= 1'b0;
      wr_random_reg <= 1'b0;
      random_reg    <= RAND_TOP;
      hit_reg       <= 1'b0;
      if_paddr_reg  <= '0;
      mem_paddr_reg <= '0;
      badvaddr_reg  <= '0;
    end else begin
      state_reg     <= state_next;
      vaddr_reg     <= vaddr_next;
      gnt_mem_reg   <= gnt_mem_next;
      rr_mem_reg    <= rr_mem_next;
      wr_random_reg <= wr_random_next;
      random_reg    <= random_next;
      if (state_reg == LOOKUP) begin
        hit_reg <= lookup_hit;
        if (gnt_mem_reg) mem_paddr_reg <= lookup_paddr;
        else             if_paddr_reg  <= lookup_paddr;
        if (!lookup_hit) badvaddr_reg <= vaddr_reg;
      end
    end
  end

  assign bus.if_ack     = (state_reg == RESP) && !gnt_mem_reg;
  assign bus.mem_ack    = (state_reg == RESP) && gnt_mem_reg;
  assign bus.if_miss    = bus.if_ack && !hit_reg;
  assign bus.mem_miss   = bus.mem_ack && !hit_reg;
  assign bus.if_paddr   = if_paddr_reg;
  assign bus.mem_paddr  = mem_paddr_reg;
  assign bus.tlbw_ack   = (state_reg == WACK);
  assign bus.tlb_inst_o = (state_reg == WRITE) ? (wr_random_reg ? INST_TLBWR : INST_TLBWI) : 32'h0;
  assign bus.tlb_addr_o = (state_reg == LOOKUP && !bypass) ? vaddr_reg : 32'h0;
  assign bus.random_o   = random_reg;
  assign bus.badvaddr_o = badvaddr_reg;
endmodule

// File: tb/tb_tlb_ctrl.sv
// Directed bench for tlb_ctrl: lookups, bypass, arbitration, writes,
// Random counter and asynchronous reset, with hand-computed expectations.
module tb_tlb_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int n_checks = 0;
  int n_fail = 0;

  tlb_ctrl_if bus ();

  tlb_ctrl #(.NUM_ENTRIES(16), .KSEG_BYPASS(1'b1)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic apply_reset();
    rst = 1'b1;
    bus.if_req = 1'b0;  bus.if_vaddr = '0;
    bus.mem_req = 1'b0; bus.mem_vaddr = '0;
    bus.tlbw_req = 1'b0; bus.tlbw_random = 1'b0;
    bus.tlb_hit_i = 1'b0; bus.tlb_paddr_i = '0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    bus.wired_i = 4'd0;
    apply_reset();
    n_checks++; if (bus.if_ack !== 1'b0) begin n_fail++; $display("FAIL reset_if_ack got %b exp 0", bus.if_ack); end
    n_checks++; if (bus.mem_ack !== 1'b0) begin n_fail++; $display("FAIL reset_mem_ack got %b exp 0", bus.mem_ack); end
    n_checks++; if (bus.if_miss !== 1'b0) begin n_fail++; $display("FAIL reset_if_miss got %b exp 0", bus.if_miss); end
    n_checks++; if (bus.mem_miss !== 1'b0) begin n_fail++; $display("FAIL reset_mem_miss got %b exp 0", bus.mem_miss); end
    n_checks++; if (bus.tlbw_ack !== 1'b0) begin n_fail++; $display("FAIL reset_tlbw_ack got %b exp 0", bus.tlbw_ack); end
    n_checks++; if (bus.if_paddr !== 32'h0) begin n_fail++; $display("FAIL reset_if_paddr got %h exp 0", bus.if_paddr); end
    n_checks++; if (bus.mem_paddr !== 32'h0) begin n_fail++; $display("FAIL reset_mem_paddr got %h exp 0", bus.mem_paddr); end
    n_checks++; if (bus.tlb_addr_o !== 32'h0) begin n_fail++; $display("FAIL reset_tlb_addr got %h exp 0", bus.tlb_addr_o); end
    n_checks++; if (bus.tlb_inst_o !== 32'h0) begin n_fail++; $display("FAIL reset_tlb_inst got %h exp 0", bus.tlb_inst_o); end
    n_checks++; if (bus.badvaddr_o !== 32'h0) begin n_fail++; $display("FAIL reset_badvaddr got %h exp 0", bus.badvaddr_o); end
    n_checks++; if (bus.random_o !== 4'd15) begin n_fail++; $display("FAIL reset_random got %0d exp 15", bus.random_o); end
    $display("txn reset: outputs checked after release");
  endtask

  task automatic test_mapped_hit();
    apply_reset();
    bus.if_req = 1'b1; bus.if_vaddr = 32'h00401000;
    bus.tlb_hit_i = 1'b1; bus.tlb_paddr_i = 32'h00023000;
    @(negedge clk);  // LOOKUP
    n_checks++; if (bus.tlb_addr_o !== 32'h00401000) begin n_fail++; $display("FAIL hit_lookup_addr got %h exp 00401000", bus.tlb_addr_o); end
    n_checks++; if (bus.if_ack !== 1'b0) begin n_fail++; $display("FAIL hit_early_ack got %b exp 0", bus.if_ack); end
    @(negedge clk);  // RESP
    n_checks++; if (bus.if_ack !== 1'b1) begin n_fail++; $display("FAIL hit_ack got %b exp 1", bus.if_ack); end
    n_checks++; if (bus.if_paddr !== 32'h00023000) begin n_fail++; $display("FAIL hit_paddr got %h exp 00023000", bus.if_paddr); end
    n_checks++; if (bus.if_miss !== 1'b0) begin n_fail++; $display("FAIL hit_miss got %b exp 0", bus.if_miss); end
    n_checks++; if (bus.mem_ack !== 1'b0) begin n_fail++; $display("FAIL hit_mem_ack got %b exp 0", bus.mem_ack); end
    n_checks++; if (bus.tlb_addr_o !== 32'h0) begin n_fail++; $display("FAIL hit_addr_resp got %h exp 0", bus.tlb_addr_o); end
    bus.if_req = 1'b0;
    bus.tlb_paddr_i = 32'hDEAD0000;
    @(negedge clk);
    n_checks++; if (bus.if_ack !== 1'b0) begin n_fail++; $display("FAIL hit_ack_one_cycle got %b exp 0", bus.if_ack); end
    n_checks++; if (bus.if_paddr !== 32'h00023000) begin n_fail++; $display("FAIL hit_paddr_hold got %h exp 00023000", bus.if_paddr); end
    $display("txn mapped_hit: if vaddr=00401000 paddr=%h", bus.if_paddr);
  endtask

  task automatic test_miss();
    apply_reset();
    bus.mem_req = 1'b1; bus.mem_vaddr = 32'h7FFFE004;
    bus.tlb_hit_i = 1'b0; bus.tlb_paddr_i = 32'h0;
    @(negedge clk);
    n_checks++; if (bus.tlb_addr_o !== 32'h7FFFE004) begin n_fail++; $display("FAIL miss_lookup_addr got %h exp 7fffe004", bus.tlb_addr_o); end
    @(negedge clk);
    n_checks++; if (bus.mem_ack !== 1'b1) begin n_fail++; $display("FAIL miss_ack got %b exp 1", bus.mem_ack); end
    n_checks++; if (bus.mem_miss !== 1'b1) begin n_fail++; $display("FAIL miss_flag got %b exp 1", bus.mem_miss); end
    n_checks++; if (bus.if_ack !== 1'b0) begin n_fail++; $display("FAIL miss_if_ack got %b exp 0", bus.if_ack); end
    n_checks++; if (bus.badvaddr_o !== 32'h7FFFE004) begin n_fail++; $display("FAIL miss_badvaddr got %h exp 7fffe004", bus.badvaddr_o); end
    bus.mem_req = 1'b0;
    @(negedge clk);
    n_checks++; if (bus.mem_miss !== 1'b0) begin n_fail++; $display("FAIL miss_flag_clear got %b exp 0", bus.mem_miss); end
    $display("txn miss: mem vaddr=7fffe004 badvaddr=%h", bus.badvaddr_o);
    // a following hit must leave badvaddr alone
    bus.if_req = 1'b1; bus.if_vaddr = 32'h00002000;
    bus.tlb_hit_i = 1'b1; bus.tlb_paddr_i = 32'h00077000;
    @(negedge clk);
    @(negedge clk);
    n_checks++; if (bus.if_ack !== 1'b1) begin n_fail++; $display("FAIL miss_then_hit_ack got %b exp 1", bus.if_ack); end
    n_checks++; if (bus.badvaddr_o !== 32'h7FFFE004) begin n_fail++; $display("FAIL badvaddr_hold got %h exp 7fffe004", bus.badvaddr_o); end
    bus.if_req = 1'b0;
    @(negedge clk);
    $display("txn hit_after_miss: if paddr=%h badvaddr=%h", bus.if_paddr, bus.badvaddr_o);
  endtask

  task automatic test_bypass_tie();
    int mem_cyc = 0;
    int if_cyc = 0;
    int addr_leak = 0;
    apply_reset();
    bus.if_req = 1'b1;  bus.if_vaddr = 32'h80001234;
    bus.mem_req = 1'b1; bus.mem_vaddr = 32'h80001234;
    bus.tlb_hit_i = 1'b0; bus.tlb_paddr_i = 32'hFFFF0000;
    for (int cyc = 1; cyc <= 8; cyc++) begin
      @(negedge clk);
      if (bus.tlb_addr_o === 32'h80001234) addr_leak++;
      if (bus.mem_ack === 1'b1) begin
        mem_cyc = cyc;
        n_checks++; if (bus.mem_paddr !== 32'h00001234) begin n_fail++; $display("FAIL bypass_mem_paddr got %h exp 00001234", bus.mem_paddr); end
        n_checks++; if (bus.mem_miss !== 1'b0) begin n_fail++; $display("FAIL bypass_mem_miss got %b exp 0", bus.mem_miss); end
        bus.mem_req = 1'b0;
      end
      if (bus.if_ack === 1'b1) begin
        if_cyc = cyc;
        n_checks++; if (bus.if_paddr !== 32'h00001234) begin n_fail++; $display("FAIL bypass_if_paddr got %h exp 00001234", bus.if_paddr); end
        bus.if_req = 1'b0;
      end
    end
    n_checks++; if (mem_cyc !== 2) begin n_fail++; $display("FAIL tie_mem_cycle got %0d exp 2", mem_cyc); end
    n_checks++; if (if_cyc !== 5) begin n_fail++; $display("FAIL tie_if_cycle got %0d exp 5", if_cyc); end
    n_checks++; if (addr_leak !== 0) begin n_fail++; $display("FAIL bypass_addr_leak got %0d exp 0", addr_leak); end
    $display("txn bypass_tie: mem ack cycle %0d, if ack cycle %0d", mem_cyc, if_cyc);
  endtask

  task automatic test_write(input logic wr_random, input logic [31:0] exp_inst);
    int pulses = 0;
    int wr_cyc = 0;
    int wack_cyc = 0;
    int acks = 0;
    int if_cyc = 0;
    logic [3:0] rnd_write = '0;
    logic [3:0] rnd_wack = '0;
    logic [31:0] inst_seen = '0;
    apply_reset();
    bus.tlbw_req = 1'b1; bus.tlbw_random = wr_random;
    bus.if_req = 1'b1; bus.if_vaddr = 32'h00401000;
    bus.tlb_hit_i = 1'b1; bus.tlb_paddr_i = 32'h00055000;
    for (int cyc = 1; cyc <= 10; cyc++) begin
      @(negedge clk);
      if (bus.tlb_inst_o !== 32'h0) begin
        pulses++; wr_cyc = cyc; inst_seen = bus.tlb_inst_o; rnd_write = bus.random_o;
      end
      if (bus.tlbw_ack === 1'b1) begin
        acks++; wack_cyc = cyc; rnd_wack = bus.random_o; bus.tlbw_req = 1'b0;
      end
      if (bus.if_ack === 1'b1) begin
        if_cyc = cyc; bus.if_req = 1'b0;
      end
    end
    n_checks++; if (inst_seen !== exp_inst) begin n_fail++; $display("FAIL write_inst got %h exp %h", inst_seen, exp_inst); end
    n_checks++; if (pulses !== 1) begin n_fail++; $display("FAIL write_pulses got %0d exp 1", pulses); end
    n_checks++; if (wr_cyc !== 1) begin n_fail++; $display("FAIL write_cycle got %0d exp 1", wr_cyc); end
    n_checks++; if (wack_cyc !== 2 || acks !== 1) begin n_fail++; $display("FAIL wack_cycle got %0d (count %0d) exp 2 (count 1)", wack_cyc, acks); end
    n_checks++; if (if_cyc !== 5) begin n_fail++; $display("FAIL write_then_if_cycle got %0d exp 5", if_cyc); end
    if (wr_random) begin
      n_checks++; if (rnd_wack !== rnd_write) begin n_fail++; $display("FAIL random_frozen got %0d exp %0d", rnd_wack, rnd_write); end
    end else begin
      n_checks++; if (rnd_wack === rnd_write) begin n_fail++; $display("FAIL random_runs_tlbwi got %0d exp not %0d", rnd_wack, rnd_write); end
    end
    $display("txn write random=%b: inst=%h wack cycle %0d, if ack cycle %0d", wr_random, inst_seen, wack_cyc, if_cyc);
  endtask

  task automatic test_random_wrap();
    logic [3:0] exp_seq [0:13];
    exp_seq = '{4'd15, 4'd14, 4'd13, 4'd12, 4'd11, 4'd10, 4'd9, 4'd8, 4'd7, 4'd6, 4'd5, 4'd4, 4'd15, 4'd14};
    bus.wired_i = 4'd4;
    apply_reset();
    for (int i = 0; i < 14; i++) begin
      if (i > 0) @(negedge clk);
      n_checks++; if (bus.random_o !== exp_seq[i]) begin n_fail++; $display("FAIL random_wired4[%0d] got %0d exp %0d", i, bus.random_o, exp_seq[i]); end
    end
    $display("txn random_wired4: sequence checked");
    bus.wired_i = 4'd15;
    apply_reset();
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      n_checks++; if (bus.random_o !== 4'd15) begin n_fail++; $display("FAIL random_wired15[%0d] got %0d exp 15", i, bus.random_o); end
    end
    $display("txn random_wired15: held at %0d", bus.random_o);
    bus.wired_i = 4'd0;
  endtask

  task automatic test_reset_midway();
    int acks = 0;
    apply_reset();
    bus.mem_req = 1'b1; bus.mem_vaddr = 32'h00401000; bus.tlb_hit_i = 1'b1;
    @(negedge clk);
    n_checks++; if (bus.tlb_addr_o !== 32'h00401000) begin n_fail++; $display("FAIL midlookup_addr got %h exp 00401000", bus.tlb_addr_o); end
    #2 rst = 1'b1;
    #1;
    n_checks++; if (bus.tlb_addr_o !== 32'h0) begin n_fail++; $display("FAIL async_rst_addr got %h exp 0", bus.tlb_addr_o); end
    n_checks++; if (bus.mem_ack !== 1'b0 || bus.if_ack !== 1'b0 || bus.tlbw_ack !== 1'b0) begin n_fail++; $display("FAIL async_rst_acks got %b%b%b exp 000", bus.if_ack, bus.mem_ack, bus.tlbw_ack); end
    bus.mem_req = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (bus.mem_ack === 1'b1 || bus.if_ack === 1'b1) acks++;
    end
    n_checks++; if (acks !== 0) begin n_fail++; $display("FAIL ack_after_abort got %0d exp 0", acks); end
    $display("txn reset_mid_lookup: acks after release %0d", acks);

    acks = 0;
    apply_reset();
    bus.tlbw_req = 1'b1; bus.tlbw_random = 1'b1;
    @(negedge clk);
    n_checks++; if (bus.tlb_inst_o !== 32'h42000006) begin n_fail++; $display("FAIL midwrite_inst got %h exp 42000006", bus.tlb_inst_o); end
    #2 rst = 1'b1;
    #1;
    n_checks++; if (bus.tlb_inst_o !== 32'h0) begin n_fail++; $display("FAIL async_rst_inst got %h exp 0", bus.tlb_inst_o); end
    bus.tlbw_req = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (bus.tlbw_ack === 1'b1) acks++;
    end
    n_checks++; if (acks !== 0) begin n_fail++; $display("FAIL wack_after_abort got %0d exp 0", acks); end
    $display("txn reset_mid_write: tlbw acks after release %0d", acks);
  endtask

  initial begin
    test_reset();
    test_mapped_hit();
    test_miss();
    test_bypass_tie();
    bus.wired_i = 4'd0;
    test_write(1'b1, 32'h42000006);
    test_write(1'b0, 32'h42000002);
    test_random_wrap();
    test_reset_midway();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
